ws2812_segment_driver: RTL and testbench

//  Parametrised WS2812 strip driver: NUM_SEG segments of LEDS_PER_SEG LEDs, one 24-bit colour per segment.

---
 rtl/ws2812_segment_driver.sv | 147 ++++++++++++++
 tb/tb_ws2812_segment_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_segment_driver.sv
// rtl/ws2812_segment_driver.sv - WS2812 strip sequencer, one colour per segment of LEDS_PER_SEG LEDs.
// Optional global brightness scaling is built when WS2812_BRIGHTNESS_EN is defined.
module ws2812_segment_driver #(
  parameter int NUM_SEG      = 12,
  parameter int LEDS_PER_SEG = 5,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 63,
  parameter int TRST         = 3000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_SEG*24-1:0] colors,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]            bright,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  dout
);

  localparam int TMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int LW   = (LEDS_PER_SEG > 1) ? $clog2(LEDS_PER_SEG) : 1;

  localparam logic [TW-1:0] T0H_C    = TW'(T0H);
  localparam logic [TW-1:0] T1H_C    = TW'(T1H);
  localparam logic [TW-1:0] TBIT_END = TW'(TBIT - 1);
  localparam logic [TW-1:0] TRST_C   = TW'(TRST);
  localparam logic [SW-1:0] SEG_LAST = SW'(NUM_SEG - 1);
  localparam logic [LW-1:0] LED_LAST = LW'(LEDS_PER_SEG - 1);

  typedef enum logic [1:0] {HOLD, IDLE, SEND, LATCH} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [4:0]    bit_cnt;
  logic [LW-1:0] led_cnt;
  logic [SW-1:0] seg_cnt;
  logic [23:0]   shadow [NUM_SEG];
  logic [23:0]   cur;
  logic [23:0]   grb;
  logic          bit_val;
  logic [TW-1:0] hi_time;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_sh;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
`endif

  // Colour of the segment in flight, reordered to wire order G,R,B.
  always_comb begin
    cur = shadow[seg_cnt];
`ifdef WS2812_BRIGHTNESS_EN
    cur = {scale(cur[23:16], bright_sh), scale(cur[15:8], bright_sh), scale(cur[7:0], bright_sh)};
`endif
    grb     = {cur[15:8], cur[23:16], cur[7:0]};
    bit_val = grb[5'd23 - bit_cnt];
    hi_time = bit_val ? T1H_C : T0H_C;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= HOLD;
      timer   <= '0;
      bit_cnt <= '0;
      led_cnt <= '0;
      seg_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= 1'b0;
    end else begin
      case (state)
        // Flush any frame cut short by reset with a full latch interval.
        HOLD: begin
          dout <= 1'b0;
          done <= 1'b0;
          if (timer == TRST_C) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
            busy  <= 1'b1;
          end
        end
        IDLE: begin
          dout    <= 1'b0;
          done    <= 1'b0;
          timer   <= '0;
          bit_cnt <= '0;
          led_cnt <= '0;
          seg_cnt <= '0;
          if (start) begin
            for (int s = 0; s < NUM_SEG; s++) shadow[s] <= colors[s*24 +: 24];
`ifdef WS2812_BRIGHTNESS_EN
            bright_sh <= bright;
`endif
            busy  <= 1'b1;
            state <= SEND;
          end else begin
            busy <= 1'b0;
          end
        end
        SEND: begin
          dout <= (timer < hi_time);
          if (timer == TBIT_END) begin
            timer <= '0;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (led_cnt == LED_LAST) begin
                led_cnt <= '0;
                if (seg_cnt == SEG_LAST) state <= LATCH;
                else                     seg_cnt <= seg_cnt + 1'b1;
              end else begin
                led_cnt <= led_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LATCH: begin
          dout <= 1'b0;
          if (timer == TRST_C) begin
            done  <= 1'b1;
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_segment_driver.sv
// tb/tb_ws2812_segment_driver.sv - scoreboard bench for ws2812_segment_driver.
module tb_ws2812_segment_driver;
  localparam int NS = 2, LP = 2, T0H = 3, T1H = 6, TBIT = 10, TRST = 20;
  localparam int FRAME_LEN = 980;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [NS*24-1:0] colors = '0;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright = 8'hFF;
`endif
  logic busy, done, dout;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit chk_en = 1'b1;
  int done_count = 0;
  int cyc = 0;

  ws2812_segment_driver #(
    .NUM_SEG(NS), .LEDS_PER_SEG(LP), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .start(start),
    .colors(colors),
`ifdef WS2812_BRIGHTNESS_EN
    .bright(bright),
`endif
    .busy(busy),
    .done(done),
    .dout(dout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic push_grb(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    push_byte(g); push_byte(r); push_byte(b);
  endtask

  task automatic push_frame(input logic [NS*24-1:0] c);
    logic [23:0] w;
    for (int s = 0; s < NS; s++) begin
      w = c[s*24 +: 24];
      for (int l = 0; l < LP; l++) push_grb(w[15:8], w[23:16], w[7:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!done) check(name, 0, 1);
  endtask

  task automatic measure_hold(output int bl, output int dh);
    int n;
    bl = 0; dh = 0; n = 0;
    while (!(bl > 0 && !busy) && n < 200) begin
      @(negedge CLOCK_50);
      n++;
      if (busy) bl++;
      if (dout) dh++;
      start = (bl == 5);
    end
    start = 1'b0;
  endtask

  // Monitor: decodes dout pulses and checks them against the queue.
  initial begin : monitor
    int hi = 0, last_rise = -1000, frame_start = 0, done_w = 0;
    bit prev = 1'b0;
    bit e;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (dout && !prev) begin
        if (chk_en && (cyc - last_rise) <= TRST) check("bit_period", cyc - last_rise, TBIT);
        if ((cyc - last_rise) > TRST) frame_start = cyc;
        last_rise = cyc;
      end
      if (dout) hi++;
      else if (prev) begin
        if (chk_en) begin
          if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("bit_high_time", hi, e ? T1H : T0H);
          end
        end
        hi = 0;
      end
      if (done) begin
        done_w++;
        if (done_w == 1) begin
          done_count++;
          if (chk_en) check("frame_length", cyc - frame_start, FRAME_LEN);
        end
      end else if (done_w > 0) begin
        check("done_width", done_w, 1);
        done_w = 0;
      end
      prev = dout;
    end
  end

  initial begin : stim
    int bl, dh, dc;
    repeat (3) @(negedge CLOCK_50);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    measure_hold(bl, dh);
    check("hold_busy_len", bl, TRST);
    check("hold_dout_high", dh, 0);
    repeat (3) @(negedge CLOCK_50);
    check("hold_start_ignored", busy, 0);

    // Frame 1: seg0 red, seg1 black.
    colors = {24'h000000, 24'hFF0000};
    push_grb(8'h00, 8'hFF, 8'h00); push_grb(8'h00, 8'hFF, 8'h00);
    push_grb(8'h00, 8'h00, 8'h00); push_grb(8'h00, 8'h00, 8'h00);
    pulse_start();
    check("accept_busy", busy, 1);
    check("accept_dout", dout, 0);
    @(negedge CLOCK_50);
    check("first_rise", dout, 1);
    wait_done("frame1_done");
    @(negedge CLOCK_50);
    check("idle_busy", busy, 0);
    check("frame1_drained", exp_q.size(), 0);

    // Colour change mid-frame must not leak into the frame in flight.
    colors = {24'hA5C30F, 24'h123456};
    push_frame(colors);
    pulse_start();
    repeat (100) @(negedge CLOCK_50);
    colors = '1;
    wait_done("shadow_done");
    @(negedge CLOCK_50);
    push_frame(colors);
    pulse_start();
    wait_done("ones_done");
    @(negedge CLOCK_50);
    check("ones_drained", exp_q.size(), 0);

    // Back-to-back frames with start held high.
    colors = {24'h0F0F0F, 24'h80FF01};
    push_frame(colors);
    push_frame(colors);
    start = 1'b1;
    wait_done("b2b_done1");
    @(negedge CLOCK_50);
    check("b2b_gap", dout, 0);
    start = 1'b0;
    @(negedge CLOCK_50);
    check("b2b_rise", dout, 1);
    repeat (50) @(negedge CLOCK_50);
    pulse_start();
    wait_done("b2b_done2");
    repeat (3) @(negedge CLOCK_50);
    check("start_not_queued", busy, 0);
    check("b2b_drained", exp_q.size(), 0);

    // Reset in the middle of a frame.
    chk_en = 1'b0;
    colors = {24'h00FF00, 24'hFFFFFF};
    pulse_start();
    repeat (300) @(negedge CLOCK_50);
    dc = done_count;
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("midreset_dout", dout, 0);
    check("midreset_busy", busy, 0);
    reset = 1'b0;
    measure_hold(bl, dh);
    check("midreset_hold_len", bl, TRST);
    check("midreset_no_done", done_count, dc);
    exp_q.delete();
    chk_en = 1'b1;

`ifdef WS2812_BRIGHTNESS_EN
    bright = 8'h7F;
    colors = {24'h000000, 24'hFF8001};
    push_grb(8'h40, 8'h7F, 8'h00); push_grb(8'h40, 8'h7F, 8'h00);
    push_grb(8'h00, 8'h00, 8'h00); push_grb(8'h00, 8'h00, 8'h00);
    pulse_start();
    wait_done("bright_done");
    @(negedge CLOCK_50);
    check("bright_drained", exp_q.size(), 0);
    bright = 8'hFF;
`endif

    repeat (5) @(negedge CLOCK_50);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
